// File: rtl/aes_pkg.sv
// Shared AES definitions used by the key-expansion datapath and its controller.
// Contents:
//   AES_NUM_ROUNDS - number of AES rounds (round keys 0..AES_NUM_ROUNDS)
//   AES_CNT_WIDTH  - width of the round counter
//   AES_WORD_WIDTH - width of one key/round-key word
//   ks_state_e     - key-schedule state codes, also seen by the datapath
//   aes_word_t     - one 32-bit key word
package aes_pkg;

    localparam int unsigned AES_NUM_ROUNDS = 10;
    localparam int unsigned AES_CNT_WIDTH  = 4;
    localparam int unsigned AES_WORD_WIDTH = 32;

    // The datapath decodes these codes directly, so they are fixed values
    // rather than a tool-chosen encoding.
    typedef enum logic [2:0] {
        KS_IDLE  = 3'b000,
        KS_LOAD  = 3'b001,
        KS_ROUND = 3'b010,
        KS_DONE  = 3'b100
    } ks_state_e;

    typedef logic [AES_WORD_WIDTH-1:0] aes_word_t;

endpackage

// File: rtl/aes_key_sched_ctrl.sv
// AES key-schedule controller: sequences the key-expansion datapath through
// LOAD (register the cipher key) and ROUND (issue round keys 0..NUM_ROUNDS),
// then pulses done for one cycle.
// Ports:
//   clk            - clock, rising edge
//   rst_n          - asynchronous active-low reset
//   start_in       - request to expand a new key (key words valid same cycle)
//   abort_in       - synchronous cancel of the running sequence
//   ready_out      - idle, start_in is accepted
//   FSM_core_out   - state code driving the datapath state input
//   core_count_out - round index driving the datapath counter input
//   rk_valid_out   - datapath round-key outputs hold round key core_count_out
//   busy_out       - sequence in progress (LOAD, ROUND or DONE)
//   done_out       - one-cycle pulse after the last round key
module aes_key_sched_ctrl
    import aes_pkg::*;
#(
    parameter int unsigned NUM_ROUNDS = AES_NUM_ROUNDS,
    parameter int unsigned CNT_WIDTH  = AES_CNT_WIDTH
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start_in,
    input  logic                 abort_in,
    output logic                 ready_out,
    output logic [2:0]           FSM_core_out,
    output logic [CNT_WIDTH-1:0] core_count_out,
    output logic                 rk_valid_out,
    output logic                 busy_out,
    output logic                 done_out
);

    localparam logic [CNT_WIDTH-1:0] LAST_ROUND = CNT_WIDTH'(NUM_ROUNDS);
    localparam logic [CNT_WIDTH-1:0] CNT_ONE    = CNT_WIDTH'(1);

    ks_state_e            state_q, state_d;
    logic [CNT_WIDTH-1:0] count_q, count_d;

    // State register and round counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= KS_IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Next-state and next-count logic
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        case (state_q)
            KS_IDLE: begin
                count_d = '0;
                if (start_in) begin
                    state_d = KS_LOAD;
                end
            end
            KS_LOAD: begin
                state_d = KS_ROUND;
                count_d = '0;
            end
            KS_ROUND: begin
                // Compare-before-increment keeps the counter from ever
                // passing LAST_ROUND or wrapping.
                if (count_q == LAST_ROUND) begin
                    state_d = KS_DONE;
                    count_d = '0;
                end else begin
                    count_d = count_q + CNT_ONE;
                end
            end
            KS_DONE: begin
                state_d = KS_IDLE;
                count_d = '0;
            end
            default: begin
                state_d = KS_IDLE;
                count_d = '0;
            end
        endcase
        // Abort wins in every state, including over a start in IDLE.
        if (abort_in) begin
            state_d = KS_IDLE;
            count_d = '0;
        end
    end

    // Output decode from registered state only
    always_comb begin
        ready_out    = 1'b0;
        busy_out     = 1'b0;
        rk_valid_out = 1'b0;
        done_out     = 1'b0;
        case (state_q)
            KS_IDLE:  ready_out = 1'b1;
            KS_LOAD:  busy_out  = 1'b1;
            KS_ROUND: begin
                busy_out     = 1'b1;
                rk_valid_out = 1'b1;
            end
            KS_DONE: begin
                busy_out = 1'b1;
                done_out = 1'b1;
            end
            default: ;
        endcase
    end

    assign FSM_core_out   = state_q;
    assign core_count_out = count_q;

endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Scoreboard bench for aes_key_sched_ctrl. Stimulus pushes the expected
// round-key and done events (cycle number plus round index); a monitor pops
// and compares whenever the DUT shows rk_valid_out or done_out.
module tb_aes_key_sched_ctrl;

    localparam int NR = 10;

    logic       clk;
    logic       rst_n;
    logic       start_in;
    logic       abort_in;
    logic       ready_out;
    logic [2:0] FSM_core_out;
    logic [3:0] core_count_out;
    logic       rk_valid_out;
    logic       busy_out;
    logic       done_out;

    aes_key_sched_ctrl #(
        .NUM_ROUNDS(NR),
        .CNT_WIDTH (4)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start_in      (start_in),
        .abort_in      (abort_in),
        .ready_out     (ready_out),
        .FSM_core_out  (FSM_core_out),
        .core_count_out(core_count_out),
        .rk_valid_out  (rk_valid_out),
        .busy_out      (busy_out),
        .done_out      (done_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cyc;
        int cnt;
    } rk_exp_t;

    rk_exp_t exp_rk[$];
    int      exp_done[$];

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: consumes expectations as the DUT presents outputs
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (rk_valid_out === 1'b1) begin
                if (exp_rk.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rk_unexpected: got count %0d expected no round key (cycle %0d)",
                             core_count_out, cyc);
                end else begin
                    rk_exp_t e;
                    e = exp_rk.pop_front();
                    check("rk_cycle", cyc, e.cyc);
                    check("rk_count", 32'(core_count_out), e.cnt);
                    check("rk_state", 32'(FSM_core_out), 32'(3'b010));
                    check("rk_busy", 32'(busy_out), 1);
                end
            end
            if (done_out === 1'b1) begin
                if (exp_done.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL done_unexpected: got done_out 1 expected 0 (cycle %0d)", cyc);
                end else begin
                    int dc;
                    dc = exp_done.pop_front();
                    check("done_cycle", cyc, dc);
                    check("done_state", 32'(FSM_core_out), 32'(3'b100));
                    check("done_rk_valid", 32'(rk_valid_out), 0);
                end
            end
        end
    end

    // Expectations for a start accepted in cycle t: round keys 0..last_k at
    // t+2.., done at t+3+NR when the sequence runs to completion.
    task automatic push_seq(input int t, input int last_k, input bit with_done);
        rk_exp_t e;
        for (int k = 0; k <= last_k; k++) begin
            e.cyc = t + 2 + k;
            e.cnt = k;
            exp_rk.push_back(e);
        end
        if (with_done) exp_done.push_back(t + 3 + NR);
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_state"}, 32'(FSM_core_out), 0);
        check({tag, "_count"}, 32'(core_count_out), 0);
        check({tag, "_ready"}, 32'(ready_out), 1);
        check({tag, "_busy"}, 32'(busy_out), 0);
        check({tag, "_rk_valid"}, 32'(rk_valid_out), 0);
        check({tag, "_done"}, 32'(done_out), 0);
    endtask

    task automatic check_drained(input string tag);
        check({tag, "_rk_left"}, exp_rk.size(), 0);
        check({tag, "_done_left"}, exp_done.size(), 0);
    endtask

    // Full sequence from a single-cycle start pulse; returns at cycle t+14.
    task automatic run_full(input string tag);
        int t;
        start_in = 1'b1;
        t = cyc;
        push_seq(t, NR, 1'b1);
        @(negedge clk);
        start_in = 1'b0;
        check({tag, "_load_state"}, 32'(FSM_core_out), 32'(3'b001));
        check({tag, "_load_count"}, 32'(core_count_out), 0);
        check({tag, "_load_ready"}, 32'(ready_out), 0);
        repeat (NR + 3) @(negedge clk);
        check_idle({tag, "_end"});
        check_drained(tag);
    endtask

    initial begin
        int t;
        rst_n    = 1'b0;
        start_in = 1'b0;
        abort_in = 1'b0;

        // Reset values while held in reset, start ignored
        @(negedge clk);
        start_in = 1'b1;
        @(negedge clk);
        check_idle("reset");
        start_in = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check_idle("post_reset");

        // Basic sequence
        run_full("seq1");

        // Start held high for 20 cycles: second run begins once ready again
        start_in = 1'b1;
        t = cyc;
        push_seq(t, NR, 1'b1);
        push_seq(t + NR + 4, NR, 1'b1);
        @(negedge clk);
        check("hold_load_state", 32'(FSM_core_out), 32'(3'b001));
        repeat (19) @(negedge clk);
        start_in = 1'b0;
        repeat (NR + 3 + 2) @(negedge clk);
        check_idle("hold_end");
        check_drained("hold");

        // Abort while core_count_out == 5
        start_in = 1'b1;
        t = cyc;
        push_seq(t, 5, 1'b0);
        @(negedge clk);
        start_in = 1'b0;
        repeat (6) @(negedge clk);
        check("abort_pre_count", 32'(core_count_out), 5);
        abort_in = 1'b1;
        @(negedge clk);
        abort_in = 1'b0;
        check_idle("abort_next");
        repeat (4) @(negedge clk);
        check_drained("abort");
        run_full("after_abort");

        // Abort and start together in IDLE
        start_in = 1'b1;
        abort_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        abort_in = 1'b0;
        check_idle("both_next");
        repeat (3) @(negedge clk);
        check_idle("both_later");

        // Asynchronous reset while core_count_out == 7
        start_in = 1'b1;
        t = cyc;
        push_seq(t, 7, 1'b0);
        @(negedge clk);
        start_in = 1'b0;
        repeat (8) @(negedge clk);
        check("rst_pre_count", 32'(core_count_out), 7);
        #2 rst_n = 1'b0;
        #1 check_idle("async_rst");
        @(negedge clk);
        check_idle("rst_held");
        check_drained("rst");
        rst_n = 1'b1;
        @(negedge clk);
        run_full("after_rst");

        repeat (3) @(negedge clk);
        check_drained("final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Absolute time limit so the run always ends
    initial begin
        #20000;
        $display("FAIL timeout: got no finish expected finish by 20000");
        $fatal(1);
    end

endmodule

// File: doc/aes_key_sched_ctrl.md
AES_KEY_SCHED_CTRL -- requirements
Module: aes_key_sched_ctrl

Interface
REQ-001 SHALL have parameter NUM_ROUNDS, default 10, meaning the number of AES rounds (round keys 0..NUM_ROUNDS).
REQ-002 SHALL have parameter CNT_WIDTH, default 4, meaning the width of the round counter.
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, meaning the asynchronous, active-low reset.
REQ-005 SHALL have port start_in, input, 1, meaning a request to expand a new cipher key; the key words are valid on the same cycle.
REQ-006 SHALL have port abort_in, input, 1, meaning a synchronous cancel of the sequence in progress.
REQ-007 SHALL have port ready_out, output, 1, meaning the controller is idle and accepts start_in.
REQ-008 SHALL have port FSM_core_out, output, 3, meaning the state code that drives the key-expansion datapath state input.
REQ-009 SHALL have port core_count_out, output, CNT_WIDTH, meaning the round index that drives the key-expansion counter input.
REQ-010 SHALL have port rk_valid_out, output, 1, meaning the datapath round-key outputs hold round key core_count_out this cycle.
REQ-011 SHALL have port busy_out, output, 1, meaning a sequence is in progress (LOAD, ROUND or DONE).
REQ-012 SHALL have port done_out, output, 1, meaning a one-cycle pulse when all NUM_ROUNDS+1 round keys have been issued.

Function
REQ-013 SHALL implement the states IDLE=3'b000, LOAD=3'b001, ROUND=3'b010 and DONE=3'b100, and SHALL drive FSM_core_out directly from the state register.
REQ-014 IDLE: ready_out=1; start_in=1 with abort_in=0 is accepted and the next state is LOAD; otherwise the state stays IDLE.
REQ-015 LOAD SHALL last exactly 1 cycle with core_count_out=0, so the datapath registers the key words; the next state is ROUND.
REQ-016 ROUND: rk_valid_out=1 every cycle, and core_count_out SHALL step 0,1,...,NUM_ROUNDS on consecutive cycles.
REQ-017 ROUND: when core_count_out==NUM_ROUNDS, the next state SHALL be DONE and the counter SHALL clear to 0.
REQ-018 DONE SHALL last exactly 1 cycle with done_out=1 and rk_valid_out=0; the next state is IDLE.
REQ-019 Latency: start accepted in cycle T -> LOAD at T+1, round key 0 at T+2, round key NUM_ROUNDS at T+2+NUM_ROUNDS, done_out at T+3+NUM_ROUNDS, ready_out=1 at T+4+NUM_ROUNDS.
REQ-020 start_in SHALL be ignored whenever ready_out=0; requests are not queued.
REQ-021 abort_in=1 in LOAD, ROUND or DONE SHALL force IDLE and count=0 on the next edge, with no done_out pulse.
REQ-022 abort_in=1 in IDLE SHALL have priority over start_in, and the start is not accepted.
REQ-023 core_count_out SHALL never exceed NUM_ROUNDS and SHALL never wrap.
REQ-024 Any unused state encoding SHALL transition to IDLE with count=0 on the next edge.
REQ-025 rk_valid_out, busy_out, ready_out and done_out SHALL be decoded from the registered state only, with no combinational path from any input.

Reset
REQ-026 rst_n=0 SHALL asynchronously set the state to IDLE and core_count_out to 0.
REQ-027 While rst_n=0, the outputs SHALL be FSM_core_out=3'b000, core_count_out=0, ready_out=1, busy_out=0, rk_valid_out=0 and done_out=0.
REQ-028 Reset asserted mid-sequence SHALL discard the sequence; the first start after rst_n deasserts SHALL behave exactly as after power-up.

Structure
REQ-029 The state encodings, NUM_ROUNDS, CNT_WIDTH and the 32-bit word width SHALL live in the shared AES package (aes_pkg), and the datapath and controller SHALL both import them.
REQ-030 The block SHALL be a single module with no sub-modules: one state register, one round counter and output decode.

Verification
REQ-031 Reset then a start pulse at cycle 0 -> FSM_core_out: 001 at cycle 1, 010 at cycles 2..12, 100 at cycle 13; core_count_out 0..10 at cycles 2..12; done_out at cycle 13 only.
REQ-032 With the key 2b7e1516_28aed2a6_abf71588_09cf4f3c wired through the datapath -> round key 10 = d014f9a8_c9ee2589_e13f0cc8_b6630ca6, seen with rk_valid_out=1 and core_count_out=10.
REQ-033 start_in held high for 20 cycles -> exactly one sequence runs, and a second sequence starts only once ready_out=1 again, with no extra done_out pulses.
REQ-034 abort_in asserted while core_count_out=5 -> IDLE next cycle, count=0, no done_out pulse; a following start yields a complete 0..10 sequence.
REQ-035 rst_n pulled low asynchronously while core_count_out=7 -> all outputs take their reset values immediately; after release, a start behaves as in REQ-031.
REQ-036 abort_in and start_in high together in IDLE -> the state stays IDLE and ready_out stays 1.
